// File: rtl/bus_console.sv
// ---------------------------------------------------------------------------
// bus_console
//
// Memory-mapped console for a simulated 8-bit CPU. It occupies an 8-byte
// register window at BASE_ADDR and provides:
//   - a TX byte FIFO that the CPU fills through DATA and a sink drains
//   - a sticky "program finished" flag with an exit code (HALT register)
//   - a free-running 16-bit cycle counter, readable as CYCLO / CYCHI
//     (reading CYCLO snapshots the high byte so CYCHI is coherent)
//   - optional interrupt on "TX FIFO drained", built only when the macro
//     BUS_CONSOLE_IRQ_EN is defined (default build: no interrupt logic)
//
// Register map (offset = i_ab[2:0]):
//   0 DATA   W: push byte          R: 00
//   1 STATUS R: {done,3'b0,overflow,irq_pend,empty,full}
//            W: bit3=1 clears overflow, bit2=1 clears irq_pend
//   2 CTRL   bit0 = irq enable (BUS_CONSOLE_IRQ_EN only, else reads 00)
//   3 HALT   W: first write sets done and exit code   R: exit code
//   4 CYCLO  R: live counter low byte, latches high byte into shadow
//   5 CYCHI  R: shadow high byte
//   6-7      reserved, read 00, writes ignored
//
// Ports:
//   clk_1mhz    bus clock, all state on the rising edge
//   rst_x       asynchronous active-low reset
//   i_ab/i_rw/i_db  CPU address, direction (1 = read), write data
//   o_db/o_db_oe    read data (combinational) and its output enable
//   o_irq_x     active-low interrupt request
//   o_tx_data/o_tx_valid/i_tx_ready  TX stream to the sink
//   o_done/o_code   program-finished flag and exit code
//
// TX handshake: a byte transfers on a rising edge where o_tx_valid and
// i_tx_ready are both high; o_tx_valid never depends on i_tx_ready, and
// o_tx_data holds the oldest byte for as long as o_tx_valid is high.
// ---------------------------------------------------------------------------
module bus_console #(
  parameter logic [15:0] BASE_ADDR  = 16'hF000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk_1mhz,
  input  logic        rst_x,
  input  logic [15:0] i_ab,
  input  logic        i_rw,
  input  logic [7:0]  i_db,
  output logic [7:0]  o_db,
  output logic        o_db_oe,
  output logic        o_irq_x,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_done,
  output logic [7:0]  o_code
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] OFF_DATA   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_CTRL   = 3'd2;
  localparam logic [2:0] OFF_HALT   = 3'd3;
  localparam logic [2:0] OFF_CYCLO  = 3'd4;
  localparam logic [2:0] OFF_CYCHI  = 3'd5;

  // Bus decode
  logic       sel;
  logic [2:0] off;
  logic       wr_en;
  logic       rd_en;

  assign sel   = (i_ab[15:3] == BASE_ADDR[15:3]);
  assign off   = i_ab[2:0];
  assign wr_en = sel && !i_rw;
  assign rd_en = sel && i_rw;

  // State
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [7:0]       code_q, code_d;
  logic [15:0]      cyc_q, cyc_d;
  logic [7:0]       shadow_q, shadow_d;
  logic             irq_pend;

  // FIFO control
  logic full;
  logic empty;
  logic push_req;
  logic push;
  logic pop;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign push_req = wr_en && (off == OFF_DATA) && !done_q;
  assign pop      = !empty && i_tx_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push     = push_req && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    done_d   = done_q;
    code_d   = code_q;
    cyc_d    = cyc_q + 16'd1;
    shadow_d = shadow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    if (wr_en && (off == OFF_STATUS) && i_db[3]) begin
      ovf_d = 1'b0;
    end
    if (push_req && full && !pop) begin
      ovf_d = 1'b1;
    end

    if (wr_en && (off == OFF_HALT) && !done_q) begin
      done_d = 1'b1;
      code_d = i_db;
    end

    if (rd_en && (off == OFF_CYCLO)) begin
      shadow_d = cyc_q[15:8];
    end
  end

  always_ff @(posedge clk_1mhz or negedge rst_x) begin
    if (!rst_x) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      code_q   <= 8'h00;
      cyc_q    <= 16'h0000;
      shadow_q <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      code_q   <= code_d;
      cyc_q    <= cyc_d;
      shadow_q <= shadow_d;
    end
  end

  // Storage carries no reset: pointers and count define what is valid.
  always_ff @(posedge clk_1mhz) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_db;
    end
  end

  // Optional interrupt
  logic [7:0] ctrl_rd;

`ifdef BUS_CONSOLE_IRQ_EN
  logic ctrl_q, ctrl_d;
  logic irq_pend_q, irq_pend_d;

  always_comb begin
    ctrl_d     = ctrl_q;
    irq_pend_d = irq_pend_q;
    if (wr_en && (off == OFF_CTRL)) begin
      ctrl_d = i_db[0];
    end
    if (wr_en && (off == OFF_STATUS) && i_db[2]) begin
      irq_pend_d = 1'b0;
    end
    // Last byte leaves and nothing arrives on the same edge: FIFO drained.
    if (pop && !push && (count_q == CNT_W'(1))) begin
      irq_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_1mhz or negedge rst_x) begin
    if (!rst_x) begin
      ctrl_q     <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign irq_pend = irq_pend_q;
  assign ctrl_rd  = {7'b0, ctrl_q};
  assign o_irq_x  = !(ctrl_q && irq_pend_q);
`else
  assign irq_pend = 1'b0;
  assign ctrl_rd  = 8'h00;
  assign o_irq_x  = 1'b1;
`endif

  // Read mux
  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'h00;
    case (off)
      OFF_STATUS: rd_data = {done_q, 3'b000, ovf_q, irq_pend, empty, full};
      OFF_CTRL:   rd_data = ctrl_rd;
      OFF_HALT:   rd_data = code_q;
      OFF_CYCLO:  rd_data = cyc_q[7:0];
      OFF_CYCHI:  rd_data = shadow_q;
      default:    rd_data = 8'h00;
    endcase
  end

  assign o_db       = sel ? rd_data : 8'h00;
  assign o_db_oe    = rd_en;
  assign o_tx_data  = mem_q[rd_ptr_q];
  assign o_tx_valid = !empty;
  assign o_done     = done_q;
  assign o_code     = code_q;

endmodule

// File: tb/tb_bus_console.sv
// ---------------------------------------------------------------------------
// tb_bus_console
//
// Directed bench for bus_console. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge. Every byte the CPU pushes is
// queued in exp_q at issue time; the TX monitor pops and compares whenever a
// transfer is presented (valid && ready at the falling edge).
// Compile with +define+BUS_CONSOLE_IRQ_EN to exercise the interrupt build.
// ---------------------------------------------------------------------------
module tb_bus_console;

`ifdef BUS_CONSOLE_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic        clk_1mhz;
  logic        rst_x;
  logic [15:0] i_ab;
  logic        i_rw;
  logic [7:0]  i_db;
  logic [7:0]  o_db;
  logic        o_db_oe;
  logic        o_irq_x;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_done;
  logic [7:0]  o_code;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] cyc_m;

  bus_console #(.BASE_ADDR(16'hF000), .FIFO_DEPTH(8)) dut (
    .clk_1mhz   (clk_1mhz),
    .rst_x      (rst_x),
    .i_ab       (i_ab),
    .i_rw       (i_rw),
    .i_db       (i_db),
    .o_db       (o_db),
    .o_db_oe    (o_db_oe),
    .o_irq_x    (o_irq_x),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_done     (o_done),
    .o_code     (o_code)
  );

  // Clock / reset block (1 MHz)
  initial begin
    clk_1mhz = 1'b0;
    forever #500 clk_1mhz = ~clk_1mhz;
  end

  // Reference cycle count: starts at 0 and counts every edge out of reset.
  always @(posedge clk_1mhz or negedge rst_x) begin
    if (!rst_x) cyc_m <= 16'h0000;
    else        cyc_m <= cyc_m + 16'd1;
  end

  // Check helpers
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // TX monitor / scoreboard
  always @(negedge clk_1mhz) begin
    if (rst_x && o_tx_valid && i_tx_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got %02h expected no byte", o_tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (o_tx_data !== e) begin
          errors++;
          $display("FAIL tx_data: got %02h expected %02h", o_tx_data, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk_1mhz); #1;
    i_ab = a; i_rw = 1'b0; i_db = d;
  endtask

  task automatic push_byte(input logic [7:0] d, input bit expect_stored);
    bus_write(16'hF000, d);
    if (expect_stored) exp_q.push_back(d);
  endtask

  task automatic bus_idle();
    @(posedge clk_1mhz); #1;
    i_ab = 16'h0000; i_rw = 1'b1; i_db = 8'h00;
  endtask

  task automatic bus_read(input logic [15:0] a, input string name, input logic [7:0] exp);
    @(posedge clk_1mhz); #1;
    i_ab = a; i_rw = 1'b1;
    @(negedge clk_1mhz);
    check8(name, o_db, exp);
    check1({name, "_oe"}, o_db_oe, 1'b1);
  endtask

  task automatic do_reset();
    rst_x = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk_1mhz);
    rst_x = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk_1mhz);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d bytes outstanding expected 0", name, exp_q.size());
    end
  endtask

  // Directed sequence
  initial begin
    i_ab = 16'h0000; i_rw = 1'b1; i_db = 8'h00; i_tx_ready = 1'b0;
    do_reset();

    // Reset state
    @(negedge clk_1mhz);
    check1("rst_tx_valid", o_tx_valid, 1'b0);
    check1("rst_irq_x", o_irq_x, 1'b1);
    check1("rst_done", o_done, 1'b0);
    check8("rst_code", o_code, 8'h00);
    check8("unsel_db", o_db, 8'h00);
    check1("unsel_oe", o_db_oe, 1'b0);
    bus_read(16'hF001, "rst_status", 8'h02);
    bus_read(16'hF005, "rst_cychi", 8'h00);

    // Counter: read CYCLO at 00FF, CYCHI next cycle shows the shadow
    for (int k = 0; k < 400; k++) begin
      @(posedge clk_1mhz); #1;
      if (cyc_m == 16'h00FF) break;
    end
    i_ab = 16'hF004; i_rw = 1'b1;
    @(negedge clk_1mhz);
    check8("cyclo_00ff", o_db, 8'hFF);
    bus_read(16'hF005, "cychi_shadow", 8'h00);
    bus_idle();

    // Three bytes out in order; no bypass on the write cycle
    i_tx_ready = 1'b1;
    push_byte(8'h41, 1'b1);
    @(negedge clk_1mhz);
    check1("no_bypass_valid", o_tx_valid, 1'b0);
    check1("oe_on_write", o_db_oe, 1'b0);
    push_byte(8'h42, 1'b1);
    @(negedge clk_1mhz);
    check1("valid_after_write", o_tx_valid, 1'b1);
    push_byte(8'h43, 1'b1);
    bus_idle();
    wait_drain("drain_3", 10);
    bus_read(16'hF001, "status_after_3", IRQ_BUILD ? 8'h06 : 8'h02);
    bus_write(16'hF001, 8'h0C);

    // Fill with sink stalled; ninth byte dropped
    i_tx_ready = 1'b0;
    for (int k = 0; k < 9; k++) push_byte(8'(k), k < 8);
    bus_read(16'hF001, "status_full_ovf", 8'h09);
    bus_write(16'hF001, 8'h08);
    bus_read(16'hF001, "status_ovf_clr", 8'h01);

    // Full FIFO: push and pop on the same edge
    @(posedge clk_1mhz); #1;
    i_tx_ready = 1'b1;
    i_ab = 16'hF000; i_rw = 1'b0; i_db = 8'h55;
    exp_q.push_back(8'h55);
    bus_read(16'hF001, "status_full_pushpop", 8'h01);
    bus_idle();
    wait_drain("drain_full", 20);
    bus_read(16'hF001, "status_drained", IRQ_BUILD ? 8'h06 : 8'h02);
    bus_write(16'hF001, 8'h04);

    // Interrupt on drain (inactive in the default build)
    bus_write(16'hF002, 8'h01);
    bus_read(16'hF002, "ctrl_read", IRQ_BUILD ? 8'h01 : 8'h00);
    i_tx_ready = 1'b0;
    push_byte(8'hA5, 1'b1);
    bus_idle();
    @(posedge clk_1mhz); #1;
    i_tx_ready = 1'b1;
    @(negedge clk_1mhz);
    check1("irq_before_pop", o_irq_x, 1'b1);
    @(negedge clk_1mhz);
    check1("irq_after_pop", o_irq_x, IRQ_BUILD ? 1'b0 : 1'b1);
    bus_write(16'hF001, 8'h04);
    bus_idle();
    @(negedge clk_1mhz);
    check1("irq_cleared", o_irq_x, 1'b1);
    wait_drain("drain_irq", 5);
    bus_write(16'hF002, 8'h00);

    // HALT: first write wins, DATA ignored afterwards
    i_tx_ready = 1'b0;
    bus_write(16'hF003, 8'h5A);
    push_byte(8'h7E, 1'b0);
    bus_write(16'hF003, 8'h11);
    bus_idle();
    @(negedge clk_1mhz);
    check1("halt_done", o_done, 1'b1);
    check8("halt_code", o_code, 8'h5A);
    check1("halt_fifo_empty", o_tx_valid, 1'b0);
    bus_read(16'hF003, "halt_read", 8'h5A);
    bus_read(16'hF001, "status_halted", 8'h82);
    bus_read(16'hF006, "reserved_read", 8'h00);
    bus_read(16'hF000, "data_read", 8'h00);
    bus_idle();

    // Reset mid-drain
    do_reset();
    push_byte(8'hC1, 1'b1);
    push_byte(8'hC2, 1'b1);
    push_byte(8'hC3, 1'b1);
    bus_idle();
    @(posedge clk_1mhz); #1;
    i_tx_ready = 1'b1;
    @(negedge clk_1mhz);
    @(negedge clk_1mhz);
    #10;
    rst_x = 1'b0;
    exp_q.delete();
    #1;
    check1("rst_mid_valid", o_tx_valid, 1'b0);
    check1("rst_mid_done", o_done, 1'b0);
    @(negedge clk_1mhz);
    rst_x = 1'b1;
    i_tx_ready = 1'b0;
    bus_read(16'hF001, "status_post_rst", 8'h02);
    bus_idle();
    repeat (2) @(negedge clk_1mhz);
    check1("post_rst_valid", o_tx_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Overall time bound
  initial begin
    #20_000_000;
    $display("FAIL timeout: got no finish expected finish within bound");
    $fatal(1, "timeout");
  end

endmodule
